// File: rtl/clock_ctrl.sv
// Upstream control for the hour/min/sec counter bank: 1 s tick generation,
// carry forwarding and debounced button-driven time setting. Outputs are registered.

module clock_ctrl_btn #(
   parameter int DB_CYC = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);
   localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

   logic          s1, s2, db, db_hist;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         db      <= 1'b0;
         db_hist <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         db_hist <= db;
         press   <= db & ~db_hist;
         // any sample equal to the current level restarts the stability window
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYC - 1)) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module clock_ctrl #(
   parameter int TICK_CYC = 50_000_000,
   parameter int DB_CYC   = 500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw0,
   input  logic       i_sw1,
   input  logic       i_sw2,
   input  logic       i_max_hit_sec,
   input  logic       i_max_hit_min,
   input  logic       i_max_hit_hour,
   output logic       o_sec_clk,
   output logic       o_min_clk,
   output logic       o_hour_clk,
   output logic       o_mode,
   output logic [1:0] o_position
);
   localparam int PW = $clog2(TICK_CYC);
   localparam logic [1:0] POS_SEC  = 2'd0;
   localparam logic [1:0] POS_MIN  = 2'd1;
   localparam logic [1:0] POS_HOUR = 2'd2;

   typedef enum logic {CLOCK = 1'b0, SETUP = 1'b1} mode_t;

   logic [2:0]    raw, press;
   mode_t         state, state_nxt;
   logic [1:0]    pos, pos_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic          hist_sec, hist_min;
   logic          sec_nxt, min_nxt, hour_nxt;
   logic          tick_end, inc;
   logic          unused_hour;

   assign unused_hour = i_max_hit_hour;
   assign raw         = {i_sw2, i_sw1, i_sw0};

   for (genvar g = 0; g < 3; g++) begin : g_btn
      clock_ctrl_btn #(.DB_CYC(DB_CYC)) u_btn (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw[g]),
         .press (press[g])
      );
   end

   assign tick_end = (presc == PW'(TICK_CYC - 1));

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      presc_nxt = '0;
      inc       = 1'b0;
      // a mode press swallows any position/increment press in the same cycle
      if (press[0]) begin
         state_nxt = (state == CLOCK) ? SETUP : CLOCK;
         if (state == CLOCK) pos_nxt = POS_SEC;
      end else if (state == SETUP) begin
         inc = press[2];
         if (press[1]) pos_nxt = (pos == POS_HOUR) ? POS_SEC : pos + 2'd1;
      end
      if (state == CLOCK && state_nxt == CLOCK && !tick_end) presc_nxt = presc + 1'b1;
      sec_nxt  = (state == CLOCK && tick_end) || (inc && pos == POS_SEC);
      min_nxt  = (state == CLOCK && i_max_hit_sec && !hist_sec) || (inc && pos == POS_MIN);
      hour_nxt = (state == CLOCK && i_max_hit_min && !hist_min) || (inc && pos == POS_HOUR);
   end

   // carry history samples in both modes so a mode change never fakes an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= CLOCK;
         pos        <= POS_SEC;
         presc      <= '0;
         hist_sec   <= 1'b0;
         hist_min   <= 1'b0;
         o_sec_clk  <= 1'b0;
         o_min_clk  <= 1'b0;
         o_hour_clk <= 1'b0;
      end else begin
         state      <= state_nxt;
         pos        <= pos_nxt;
         presc      <= presc_nxt;
         hist_sec   <= i_max_hit_sec;
         hist_min   <= i_max_hit_min;
         o_sec_clk  <= sec_nxt;
         o_min_clk  <= min_nxt;
         o_hour_clk <= hour_nxt;
      end
   end

   assign o_mode     = (state == SETUP);
   assign o_position = pos;
endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_CYC=10, DB_CYC=4.
module tb_clock_ctrl;
   localparam int TICK = 10;
   localparam int DB   = 4;
   localparam int LAT  = DB + 4;  // raw button rise to registered output change

   logic clk = 1'b0, rst_n = 1'b0;
   logic sw0 = 1'b0, sw1 = 1'b0, sw2 = 1'b0;
   logic mhs = 1'b0, mhm = 1'b0, mhh = 1'b0;
   logic sec_clk, min_clk, hour_clk, mode;
   logic [1:0] pos;
   logic [5:0] obs;
   int n_vec = 0, n_err = 0;

   assign obs = {sec_clk, min_clk, hour_clk, mode, pos};

   always #5 clk = ~clk;

   clock_ctrl #(.TICK_CYC(TICK), .DB_CYC(DB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_sw0          (sw0),
      .i_sw1          (sw1),
      .i_sw2          (sw2),
      .i_max_hit_sec  (mhs),
      .i_max_hit_min  (mhm),
      .i_max_hit_hour (mhh),
      .o_sec_clk      (sec_clk),
      .o_min_clk      (min_clk),
      .o_hour_clk     (hour_clk),
      .o_mode         (mode),
      .o_position     (pos)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic btn_press(input logic [2:0] m);
      {sw2, sw1, sw0} = m;
      repeat (LAT) step();
      {sw2, sw1, sw0} = 3'b000;
      repeat (LAT) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_vec++;
      if (obs !== 6'b0) begin
         n_err++;
         $display("FAIL reset_state: got %b want %b", obs, 6'b0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_tick();
      logic [5:0] exp_v;
      for (int e = 1; e <= 35; e++) begin
         step();
         exp_v = {(e % TICK == 0), 5'b0};
         n_vec++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL tick e=%0d: got %b want %b", e, obs, exp_v);
         end
      end
   endtask

   task automatic test_carry();
      mhs = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         n_vec++;
         if ({min_clk, hour_clk} !== {(e == 1), 1'b0}) begin
            n_err++;
            $display("FAIL carry_sec e=%0d: got min/hour %b%b want %b0", e, min_clk, hour_clk, (e == 1));
         end
      end
      mhs = 1'b0;
      repeat (2) step();
      mhm = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         n_vec++;
         if ({min_clk, hour_clk} !== {1'b0, (e == 1)}) begin
            n_err++;
            $display("FAIL carry_min e=%0d: got min/hour %b%b want 0%b", e, min_clk, hour_clk, (e == 1));
         end
      end
      mhm = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_setup();
      logic [1:0] ep;
      sw0 = 1'b1;
      for (int e = 1; e <= LAT; e++) begin
         step();
         if (e == LAT - 1) begin
            n_vec++;
            if (mode !== 1'b0) begin
               n_err++;
               $display("FAIL mode_early: got %b want 0", mode);
            end
         end
      end
      n_vec++;
      if ({mode, pos} !== 3'b100) begin
         n_err++;
         $display("FAIL enter_setup: got mode/pos %b%b want 100", mode, pos);
      end
      sw0 = 1'b0;
      for (int e = 1; e <= LAT; e++) begin
         step();
         n_vec++;
         if (obs !== 6'b000100) begin
            n_err++;
            $display("FAIL setup_frozen e=%0d: got %b want 000100", e, obs);
         end
      end
      for (int k = 1; k <= 2; k++) begin
         sw1 = 1'b1;
         for (int e = 1; e <= 2 * LAT; e++) begin
            if (e == LAT + 1) sw1 = 1'b0;
            step();
            ep = (e >= LAT) ? 2'(k) : 2'(k - 1);
            n_vec++;
            if (obs !== {4'b0001, ep}) begin
               n_err++;
               $display("FAIL position k=%0d e=%0d: got %b want %b", k, e, obs, {4'b0001, ep});
            end
         end
      end
      sw2 = 1'b1;
      for (int e = 1; e <= 2 * LAT; e++) begin
         if (e == LAT + 2) sw2 = 1'b0;
         step();
         n_vec++;
         if (obs !== {2'b00, (e == LAT), 3'b110}) begin
            n_err++;
            $display("FAIL inc_hour e=%0d: got %b want %b", e, obs, {2'b00, (e == LAT), 3'b110});
         end
      end
   endtask

   task automatic test_bounce();
      btn_press(3'b010);
      btn_press(3'b010);
      n_vec++;
      if ({mode, pos} !== 3'b101) begin
         n_err++;
         $display("FAIL to_min: got mode/pos %b%b want 101", mode, pos);
      end
      // glitches of 3 high cycles separated by 2 low, then stable high from cycle 10
      for (int c = 0; c < 24; c++) begin
         sw2 = (c <= 2) || (c >= 5 && c <= 7) || (c >= 10);
         step();
         n_vec++;
         if ({sec_clk, min_clk, hour_clk} !== {1'b0, (c + 1 == 10 + LAT), 1'b0}) begin
            n_err++;
            $display("FAIL bounce c=%0d: got s/m/h %b%b%b want 0%b0", c, sec_clk, min_clk, hour_clk,
                     (c + 1 == 10 + LAT));
         end
      end
      sw2 = 1'b0;
      repeat (LAT) step();
      mhm = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         n_vec++;
         if (hour_clk !== 1'b0) begin
            n_err++;
            $display("FAIL setup_carry e=%0d: got hour_clk %b want 0", e, hour_clk);
         end
      end
      mhm = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_exit();
      logic [3:0] exp_v;
      mhs = 1'b1;
      repeat (3) step();
      for (int c = 0; c < 20; c++) begin
         sw0 = (c < LAT);
         step();
         exp_v = {(c + 1 == LAT + TICK), 2'b00, (c + 1 < LAT)};
         n_vec++;
         if ({sec_clk, min_clk, hour_clk, mode} !== exp_v) begin
            n_err++;
            $display("FAIL exit_setup e=%0d: got s/m/h/mode %b%b%b%b want %b", c + 1, sec_clk, min_clk,
                     hour_clk, mode, exp_v);
         end
      end
      mhs = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit got = 0;
      for (int e = 0; e < 15 && !got; e++) begin
         step();
         if (sec_clk === 1'b1) got = 1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL wait_tick: got no sec_clk pulse want one within 15 cycles");
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs !== 6'b0) begin
         n_err++;
         $display("FAIL reset_in_pulse: got %b want %b", obs, 6'b0);
      end
      repeat (2) step();
      rst_n = 1'b1;
      btn_press(3'b001);
      n_vec++;
      if ({mode, pos} !== 3'b100) begin
         n_err++;
         $display("FAIL setup_after_reset: got mode/pos %b%b want 100", mode, pos);
      end
      // sw1 and sw2 together: increment SEC, then advance to MIN
      {sw2, sw1} = 2'b11;
      for (int e = 1; e <= LAT; e++) begin
         step();
         n_vec++;
         if (obs !== {(e == LAT), 3'b001, (e >= LAT) ? 2'd1 : 2'd0}) begin
            n_err++;
            $display("FAIL sw1_sw2 e=%0d: got %b want %b", e, obs,
                     {(e == LAT), 3'b001, (e >= LAT) ? 2'd1 : 2'd0});
         end
      end
      {sw2, sw1} = 2'b00;
      repeat (LAT) step();
      btn_press(3'b010);
      n_vec++;
      if ({mode, pos} !== 3'b110) begin
         n_err++;
         $display("FAIL to_hour: got mode/pos %b%b want 110", mode, pos);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs !== 6'b0) begin
         n_err++;
         $display("FAIL reset_in_setup: got %b want %b", obs, 6'b0);
      end
      repeat (2) step();
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         n_vec++;
         if (obs !== {(e == TICK), 5'b0}) begin
            n_err++;
            $display("FAIL tick_after_reset e=%0d: got %b want %b", e, obs, {(e == TICK), 5'b0});
         end
      end
   endtask

   initial begin
      test_reset();
      test_tick();
      test_carry();
      test_setup();
      test_bounce();
      test_exit();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Upstream control stage for the hour/min/sec counter bank. It derives a 1 Hz tick from the system clock and drives the three counter clock inputs: `o_sec_clk`, `o_min_clk` and `o_hour_clk`. In CLOCK mode the seconds counter runs from the tick, and the minute and hour counters advance from the carries returned by the bank. In SETUP mode time is frozen, and debounced push-buttons select a field and increment it.

Parameters:
- TICK_CYC, 50_000_000, clk cycles per 1 s tick (≥2).
- DB_CYC, 500_000, cycles a synchronized button must be stable before its debounced level changes (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_sw0  in  1  mode button, raw, active-high, asynchronous
- i_sw1  in  1  position button, raw, active-high, asynchronous
- i_sw2  in  1  increment button, raw, active-high, asynchronous
- i_max_hit_sec  in  1  seconds-counter wrap flag from the counter bank
- i_max_hit_min  in  1  minutes-counter wrap flag from the counter bank
- i_max_hit_hour  in  1  hours-counter wrap flag; monitored only, no action
- o_sec_clk  out  1  seconds counter clock (rising edge = +1)
- o_min_clk  out  1  minutes counter clock
- o_hour_clk  out  1  hours counter clock
- o_mode  out  1  0 = CLOCK, 1 = SETUP
- o_position  out  2  0 = SEC, 1 = MIN, 2 = HOUR; 3 is never produced

Behaviour:
- Reset: rst_n is asynchronous, active-low; the clock is clk. All registers clear:
  - outputs: o_*_clk = 0, o_mode = 0, o_position = 0;
  - internal: prescaler = 0, debounce state = 0, edge-detect history = 0.
- All outputs are driven directly from flops; no combinational path from any input to any output.
- Button conditioning, per button:
  - 2-FF synchronizer.
  - Stability counter: the debounced level takes the synchronized value after DB_CYC consecutive equal samples.
  - A one-cycle press pulse is generated on each debounced 0→1 transition; releases produce nothing.
  - Latency from a clean raw rise to the press pulse is DB_CYC+3 cycles.
- Mode FSM (states CLOCK, SETUP):
  - A sw0 press toggles the state.
  - Entering SETUP sets o_position = SEC.
  - Entering CLOCK clears the prescaler to 0.
- Position: a sw1 press in SETUP advances SEC→MIN→HOUR→SEC. Ignored in CLOCK.
- Prescaler:
  - Counts 0..TICK_CYC-1 and wraps, in CLOCK mode only; held at 0 in SETUP.
  - In CLOCK, o_sec_clk is high for exactly the one cycle after the prescaler equals TICK_CYC-1.
  - First tick after reset or after entering CLOCK: o_sec_clk high in cycle TICK_CYC (counting the first counted cycle as 1).
- Carries:
  - Edge detectors on i_max_hit_sec and i_max_hit_min sample every cycle in both modes, so no edge is lost or invented on a mode change.
  - In CLOCK, a 0→1 edge sampled in cycle n makes o_min_clk (resp. o_hour_clk) high for exactly cycle n+1.
  - In SETUP, detected edges are discarded: no carry propagation while setting.
- Increment: a sw2 press in SETUP gives a one-cycle high pulse on the selected output (o_sec_clk / o_min_clk / o_hour_clk) in the cycle after the press pulse. Ignored in CLOCK.
- Pulse rules:
  - Every output pulse is exactly 1 cycle wide and followed by ≥1 low cycle.
  - At most one of the three clock outputs pulses per cycle from the increment path.
  - Tick and carry pulses may coincide only if the bank timing makes them coincide.
- Simultaneous press pulses, same cycle:
  - sw0 has priority: the mode toggles and sw1/sw2 are dropped.
  - sw1 + sw2 in SETUP: increment the currently selected field, then advance the position.
- Outputs are held steady while buttons bounce; bounces shorter than DB_CYC produce no pulse.
- rst_n asserted mid-operation: immediate return to reset values, including an in-flight pulse forced low.

Test Plan (TICK_CYC=10, DB_CYC=4):
1. Release reset, idle 35 cycles → o_sec_clk pulses at cycles 10, 20, 30; each pulse 1 cycle wide; o_mode = 0.
2. Raise i_max_hit_sec for 10 cycles in CLOCK → o_min_clk high for exactly 1 cycle, one cycle after the rise; no second pulse while the flag stays high. Same check for i_max_hit_min → o_hour_clk.
3. Press sw0, holding ≥6 cycles → o_mode = 1, o_position = 0, o_sec_clk stays low. Then:
   - press sw1 twice → o_position 1 then 2;
   - press sw2 → a single o_hour_clk pulse, and o_sec_clk / o_min_clk stay low.
4. Bounce sw2 (3-cycle high glitches, then stable high) in SETUP/MIN → exactly one o_min_clk pulse. Raising i_max_hit_min while in SETUP produces no o_hour_clk pulse.
5. In SETUP with i_max_hit_sec already high, press sw0 → back to CLOCK with no spurious o_min_clk; next o_sec_clk pulse comes 10 cycles after the mode change.
6. Assert rst_n low during an o_sec_clk pulse and in SETUP/HOUR → all outputs 0 immediately; after release, mode = CLOCK, position = SEC, first tick at cycle 10.
